seg7_capture: RTL

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_pkg.sv | 52 +++++
 rtl/seg7_capture_if.sv | 35 +++
 rtl/seg_to_bcd.sv | 30 +++
 rtl/seg7_capture.sv | 131 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the 7-segment display capture block.
package seg7_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 8;

  // Active-high segment patterns, bit0 = a ... bit6 = g
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
  localparam logic [CODE_W-1:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // One sample of the multiplexed display bus
  typedef struct packed {
    logic [DIGITS-1:0] sel;
    logic [SEG_W-1:0]  seg;
  } disp_sample_t;

  // True when exactly one digit enable is active
  function automatic logic is_onehot(input logic [DIGITS-1:0] v);
    return (v != '0) && ((v & (v - DIGITS'(1))) == '0);
  endfunction

  // Digit index of a one-hot enable (only meaningful when v is one-hot)
  function automatic logic [1:0] sel_index(input logic [DIGITS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Display bus in, captured digit state out.
interface seg7_capture_if;
  import seg7_pkg::*;

  logic [DIGITS-1:0]        digit_sel;
  logic [SEG_W-1:0]         segment;
  logic [DIGITS*CODE_W-1:0] digits;
  logic [DIGITS-1:0]        digit_valid;
  logic [DIGITS-1:0]        digit_err;
  logic                     capture_stb;
  logic                     frame_valid;

  // Display driver side: drives the scan bus, observes captures
  modport master (
    output digit_sel,
    output segment,
    input  digits,
    input  digit_valid,
    input  digit_err,
    input  capture_stb,
    input  frame_valid
  );

  // Capture block side
  modport slave (
    input  digit_sel,
    input  segment,
    output digits,
    output digit_valid,
    output digit_err,
    output capture_stb,
    output frame_valid
  );

endinterface

// File: rtl/seg_to_bcd.sv
// Combinational segment-pattern to digit-code decoder; unknown patterns map to CODE_ERR.
module seg_to_bcd
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]  segment,
  output logic [CODE_W-1:0] value_c,
  output logic              invalid_c
);

  // Pattern lookup with error fallback
  always_comb begin
    value_c   = CODE_ERR;
    invalid_c = 1'b1;
    case (segment)
      SEG_0:     begin value_c = 4'd0;       invalid_c = 1'b0; end
      SEG_1:     begin value_c = 4'd1;       invalid_c = 1'b0; end
      SEG_2:     begin value_c = 4'd2;       invalid_c = 1'b0; end
      SEG_3:     begin value_c = 4'd3;       invalid_c = 1'b0; end
      SEG_4:     begin value_c = 4'd4;       invalid_c = 1'b0; end
      SEG_5:     begin value_c = 4'd5;       invalid_c = 1'b0; end
      SEG_6:     begin value_c = 4'd6;       invalid_c = 1'b0; end
      SEG_7:     begin value_c = 4'd7;       invalid_c = 1'b0; end
      SEG_8:     begin value_c = 4'd8;       invalid_c = 1'b0; end
      SEG_9:     begin value_c = 4'd9;       invalid_c = 1'b0; end
      SEG_BLANK: begin value_c = CODE_BLANK; invalid_c = 1'b0; end
      default:   begin value_c = CODE_ERR;   invalid_c = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures digits from a multiplexed 4-digit 7-segment bus once each
// one-hot {digit_sel, segment} sample has been stable for STABLE_CYCLES clocks.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  seg7_capture_if.slave bus
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_param
    $error("seg7_capture: STABLE_CYCLES must be within 2..255");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                        state;
  disp_sample_t                  lat;
  logic [CNT_W-1:0]              cnt;
  logic [DIGITS-1:0]             mask;
  logic [DIGITS-1:0][CODE_W-1:0] digit_q;
  logic [DIGITS-1:0]             valid_q;
  logic [DIGITS-1:0]             err_q;
  logic                          stb_q;
  logic                          frame_q;

  disp_sample_t      cur_c;
  logic              cur_onehot_c;
  logic              same_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic [CODE_W-1:0] dec_value_c;
  logic              dec_invalid_c;
  logic [1:0]        lat_idx_c;
  logic [DIGITS-1:0] mask_next_c;

  // Current bus sample and its relation to the latched one
  assign cur_c.sel    = bus.digit_sel;
  assign cur_c.seg    = bus.segment;
  assign cur_onehot_c = is_onehot(cur_c.sel);
  assign same_c       = (cur_c == lat);
  assign cnt_inc_c    = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign lat_idx_c    = sel_index(lat.sel);
  assign mask_next_c  = mask | lat.sel;

  // Decode the latched pattern; it equals the bus value on the capture cycle
  seg_to_bcd u_dec (
    .segment   (lat.seg),
    .value_c   (dec_value_c),
    .invalid_c (dec_invalid_c)
  );

  // Stability FSM, digit registers and frame tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lat     <= '0;
      cnt     <= '0;
      mask    <= '0;
      digit_q <= '0;
      valid_q <= '0;
      err_q   <= '0;
      stb_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      stb_q   <= 1'b0;
      frame_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cur_onehot_c) begin
            lat   <= cur_c;
            cnt   <= CNT_ONE;
            state <= SETTLE;
          end
        end

        SETTLE: begin
          if (same_c) begin
            cnt <= cnt_inc_c;
            if (cnt_inc_c == CNT_MAX) begin
              digit_q[lat_idx_c] <= dec_value_c;
              valid_q[lat_idx_c] <= 1'b1;
              err_q[lat_idx_c]   <= dec_invalid_c;
              stb_q              <= 1'b1;
              if (mask_next_c == '1) begin
                frame_q <= 1'b1;
                mask    <= '0;
              end else begin
                mask    <= mask_next_c;
              end
              state <= HOLD;
            end
          end else if (cur_onehot_c) begin
            lat <= cur_c;
            cnt <= CNT_ONE;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end

        HOLD: begin
          if (!same_c) begin
            if (cur_onehot_c) begin
              lat   <= cur_c;
              cnt   <= CNT_ONE;
              state <= SETTLE;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.digits      = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_err   = err_q;
  assign bus.capture_stb = stb_q;
  assign bus.frame_valid = frame_q;

endmodule
